puf_eval_controller: RTL and testbench
======================================

Name: puf_eval_controller

Overview:
- Sequencer in front of `arbiter_puf`.
- Accepts a 64-bit challenge over a valid/ready command channel and drives it onto the PUF challenge bus.
- Waits a programmable settle time, then samples the registered PUF response over several consecutive cycles.
- Returns a majority-voted response bit and its ones count over a valid/ready response channel.
- One evaluation in flight at a time.

Parameters:
- CHAL_W, 64, challenge width; must match `arbiter_puf` challenge.
- SETTLE_CYC, 4, cycles between challenge update and first sample; legal range 1..255.
- NUM_SAMPLES, 5, response samples per evaluation; odd, legal range 1..255.

Ports:
- clk  input  1  system clock; same clock as `arbiter_puf`.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  challenge offered.
- cmd_ready  output  1  controller idle; can accept a challenge.
- cmd_challenge  input  CHAL_W  challenge to evaluate.
- puf_challenge  output  CHAL_W  registered challenge driven to `arbiter_puf`.
- puf_response  input  1  `arbiter_puf` response; already registered in the clk domain.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_bit  output  1  majority-voted response.
- rsp_ones  output  8  count of 1 samples in this evaluation.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All flops clear immediately on rst_n low, independent of clk.
- Reset values:
  - state=IDLE.
  - puf_challenge=0, rsp_valid=0, rsp_bit=0, rsp_ones=0, busy=0.
  - Counters=0.
  - cmd_ready=1 once rst_n is high.
- States: IDLE, SETTLE, SAMPLE, DONE (2-bit encoding).
- IDLE:
  - cmd_ready=1.
  - On a clk edge with cmd_valid=1: puf_challenge<=cmd_challenge, settle counter<=0, ones counter<=0, sample counter<=0, go to SETTLE.
  - cmd_challenge is captured only at that edge.
- SETTLE:
  - cmd_ready=0.
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYC-1, go to SAMPLE.
  - Occupies exactly SETTLE_CYC cycles.
- SAMPLE:
  - Each edge: ones<=ones+puf_response, sample counter increments.
  - On the edge taking sample NUM_SAMPLES, go to DONE. That edge also loads:
    - rsp_ones = final count, including the last sample.
    - rsp_bit = (final count > NUM_SAMPLES/2), using integer division.
    - rsp_valid = 1.
- DONE:
  - rsp_valid, rsp_bit and rsp_ones hold stable until an edge with rsp_ready=1.
  - At that edge: rsp_valid<=0, go to IDLE.
  - rsp_bit and rsp_ones retain their last values after the handshake.
- Latency: accept edge E0 → rsp_valid high after edge E0+SETTLE_CYC+NUM_SAMPLES. With defaults, 9 cycles.
- Minimum spacing between accepts: SETTLE_CYC+NUM_SAMPLES+2 cycles when rsp_ready is held high. DONE lasts at least one cycle, and IDLE is re-entered before the next accept. No skid path.
- puf_challenge holds its value from accept until the next accept. It never changes while in SETTLE or SAMPLE.
- Widths:
  - Counters and rsp_ones are 8 bits; no wrap is possible within the legal parameter range.
  - Illegal parameters (SETTLE_CYC=0, even NUM_SAMPLES, or >255) trigger an elaboration-time `$error`.
- Boundaries:
  - cmd_valid while not IDLE: ignored. cmd_ready=0 and no capture.
  - rsp_ready while not DONE: ignored.
  - NUM_SAMPLES=1: one SAMPLE cycle; rsp_bit=puf_response.
  - Reset asserted mid-evaluation: evaluation aborted with no response produced. puf_challenge clears to 0, state returns to IDLE.

Optional Feature:
- Macro: PUF_STABILITY_FLAG_EN.
- Defined:
  - Adds output port rsp_stable (1 bit, reset 0), loaded at the same edge as rsp_bit.
  - rsp_stable=1 iff the final count is 0 or NUM_SAMPLES, i.e. all samples agree. Otherwise 0.
  - Holds with rsp_bit.
- Undefined: port and its logic are absent. All other behaviour is identical.

Test Plan:
- Defaults; reset then cmd_valid=1 with challenge 64'hDEADBEEF_01234567 for one cycle, puf_response tied 1, rsp_ready=1 → cmd_ready drops next cycle; puf_challenge=64'hDEADBEEF_01234567; rsp_valid rises 9 cycles after accept edge for exactly 1 cycle; rsp_bit=1, rsp_ones=5, rsp_stable=1.
- puf_response pattern 1,0,1,0,0 across SAMPLE cycles → rsp_bit=0, rsp_ones=2, rsp_stable=0; pattern 1,1,0,1,0 → rsp_bit=1, rsp_ones=3.
- rsp_ready held 0 for 6 cycles after rsp_valid → rsp_valid, rsp_bit, rsp_ones stable all 6 cycles; cmd_valid pulses during that time are ignored and cmd_ready stays 0; rsp_ready=1 → IDLE next cycle.
- cmd_valid toggled with a new challenge during SETTLE and SAMPLE → puf_challenge unchanged; no extra evaluation occurs.
- rst_n asserted asynchronously mid-SAMPLE (between clock edges) → all outputs zero immediately; rsp_valid never asserted; after release cmd_ready=1 and a fresh evaluation completes normally.
- SETTLE_CYC=1, NUM_SAMPLES=1 build, puf_response=0 → rsp_valid 2 cycles after accept edge, rsp_bit=0, rsp_ones=0.

Source files
------------

// File: rtl/puf_eval_controller_if.sv
// puf_eval_controller_if: command/response handshake bundle for puf_eval_controller.
// Ports (signals): cmd_valid, cmd_ready, cmd_challenge[CHAL_W], rsp_valid, rsp_ready,
// rsp_bit, rsp_ones[8], and rsp_stable only when PUF_STABILITY_FLAG_EN is defined.
// master = host side, slave = controller side.
interface puf_eval_controller_if #(parameter int CHAL_W = 64);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CHAL_W-1:0] cmd_challenge;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_bit;
  logic [7:0]        rsp_ones;
`ifdef PUF_STABILITY_FLAG_EN
  logic              rsp_stable;
  modport master (output cmd_valid, cmd_challenge, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_bit, rsp_ones, rsp_stable);
  modport slave  (input  cmd_valid, cmd_challenge, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_bit, rsp_ones, rsp_stable);
`else
  modport master (output cmd_valid, cmd_challenge, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_bit, rsp_ones);
  modport slave  (input  cmd_valid, cmd_challenge, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_bit, rsp_ones);
`endif
endinterface

// File: rtl/puf_eval_controller.sv
// puf_eval_controller: sequences one arbiter_puf evaluation (settle, multi-sample, majority vote).
// Ports: clk, rst_n (async active-low), bus (slave: cmd valid/ready/challenge, rsp valid/ready/bit/ones),
// puf_challenge (registered challenge to the PUF), puf_response (registered PUF output), busy.
// Optional macro PUF_STABILITY_FLAG_EN adds bus.rsp_stable (all samples agreed).
module puf_eval_controller #(
  parameter int CHAL_W      = 64,
  parameter int SETTLE_CYC  = 4,
  parameter int NUM_SAMPLES = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  puf_eval_controller_if.slave   bus,
  output logic [CHAL_W-1:0]      puf_challenge,
  input  logic                   puf_response,
  output logic                   busy
);
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || NUM_SAMPLES < 1 || NUM_SAMPLES > 255 ||
      NUM_SAMPLES % 2 == 0) begin : g_bad_param
    $error("puf_eval_controller: illegal SETTLE_CYC/NUM_SAMPLES");
  end
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic [7:0] ones;
  logic [7:0] ones_n;
  // ones count including the sample taken at the current edge
  assign ones_n        = ones + 8'(puf_response);
  assign bus.cmd_ready = rst_n && state == IDLE;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ones          <= '0;
      puf_challenge <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_bit   <= 1'b0;
      bus.rsp_ones  <= '0;
`ifdef PUF_STABILITY_FLAG_EN
      bus.rsp_stable <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          puf_challenge <= bus.cmd_challenge;
          cnt           <= '0;
          ones          <= '0;
          state         <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          ones <= ones_n;
          cnt  <= cnt + 8'd1;
          if (cnt == 8'(NUM_SAMPLES - 1)) begin
            bus.rsp_ones  <= ones_n;
            bus.rsp_bit   <= ones_n > 8'(NUM_SAMPLES / 2);
            bus.rsp_valid <= 1'b1;
`ifdef PUF_STABILITY_FLAG_EN
            bus.rsp_stable <= ones_n == 8'd0 || ones_n == 8'(NUM_SAMPLES);
`endif
            state         <= DONE;
          end
        end
        DONE: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_puf_eval_controller.sv
// tb_puf_eval_controller: table-driven scoreboard bench for puf_eval_controller (default and 1/1 builds).
module tb_puf_eval_controller;
  localparam int S0 = 4;
  localparam int N0 = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  puf_eval_controller_if #(.CHAL_W(64)) bus0 ();
  puf_eval_controller_if #(.CHAL_W(64)) bus1 ();
  logic [63:0] pc0, pc1;
  logic pr0 = 1'b0;
  logic pr1 = 1'b0;
  logic busy0, busy1;
  puf_eval_controller #(.CHAL_W(64)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .puf_challenge(pc0), .puf_response(pr0), .busy(busy0)
  );
  puf_eval_controller #(.CHAL_W(64), .SETTLE_CYC(1), .NUM_SAMPLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .puf_challenge(pc1), .puf_response(pr1), .busy(busy1)
  );
  typedef struct {
    logic [63:0] chal;
    logic [4:0]  pat;
    int          hold;
    bit          noise;
    logic        exp_bit;
    logic [7:0]  exp_ones;
    logic        exp_stable;
  } vec_t;
  typedef struct {
    logic       b;
    logic [7:0] ones;
    logic       st;
  } exp_t;
  vec_t vecs[5];
  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask
  task automatic run_eval(input vec_t v);
    exp_t e;
    int lat;
    bit got;
    exp_q.push_back('{b: v.exp_bit, ones: v.exp_ones, st: v.exp_stable});
    bus0.cmd_valid = 1'b1;
    bus0.cmd_challenge = v.chal;
    bus0.rsp_ready = v.hold == 0;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    chk("cmd_ready_drop", bus0.cmd_ready, 0);
    chk("puf_challenge_load", pc0, v.chal);
    lat = 0;
    got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      pr0 = (c > S0 && c <= S0 + N0) ? v.pat[c-S0-1] : 1'b0;
      if (v.noise) begin
        bus0.cmd_valid = c[0];
        bus0.cmd_challenge = ~v.chal;
      end
      @(posedge clk); #1;
      if (bus0.rsp_valid) begin
        got = 1;
        lat = c;
      end else begin
        chk("challenge_hold", pc0, v.chal);
        chk("busy_ready_low", {busy0, bus0.cmd_ready}, 2'b10);
      end
    end
    bus0.cmd_valid = 1'b0;
    chk("latency", lat, S0 + N0);
    e = exp_q.pop_front();
    chk("rsp_bit", bus0.rsp_bit, e.b);
    chk("rsp_ones", bus0.rsp_ones, e.ones);
`ifdef PUF_STABILITY_FLAG_EN
    chk("rsp_stable", bus0.rsp_stable, e.st);
`endif
    for (int h = 0; h < v.hold; h++) begin
      bus0.cmd_valid = (h % 2) == 0;
      bus0.cmd_challenge = ~v.chal;
      @(posedge clk); #1;
      chk("hold_valid", bus0.rsp_valid, 1);
      chk("hold_bit", bus0.rsp_bit, e.b);
      chk("hold_ones", bus0.rsp_ones, e.ones);
      chk("hold_cmd_ready", bus0.cmd_ready, 0);
      chk("hold_challenge", pc0, v.chal);
    end
    bus0.cmd_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_one_cycle", bus0.rsp_valid, 0);
    chk("idle_after_hs", {busy0, bus0.cmd_ready}, 2'b01);
    chk("bit_retained", bus0.rsp_bit, e.b);
    chk("ones_retained", bus0.rsp_ones, e.ones);
    bus0.rsp_ready = 1'b0;
  endtask
  task automatic reset_mid_sample();
    bus0.cmd_valid = 1'b1;
    bus0.cmd_challenge = 64'hA5A5_0000_FFFF_1234;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    pr0 = 1'b1;
    repeat (S0 + 2) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_challenge", pc0, 0);
    chk("rst_valid", bus0.rsp_valid, 0);
    chk("rst_bit_ones", {bus0.rsp_bit, bus0.rsp_ones}, 0);
    chk("rst_busy_ready", {busy0, bus0.cmd_ready}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", bus0.cmd_ready, 1);
    repeat (12) begin
      @(posedge clk); #1;
      chk("no_rsp_after_abort", {bus0.rsp_valid, busy0}, 0);
    end
    pr0 = 1'b0;
  endtask
  task automatic run_small(input logic r);
    int lat;
    pr1 = r;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_challenge = 64'h5;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus1.rsp_valid) lat = c;
    end
    chk("small_latency", lat, 2);
    chk("small_bit", bus1.rsp_bit, r);
    chk("small_ones", bus1.rsp_ones, {7'd0, r});
    @(posedge clk); #1;
    chk("small_idle", {bus1.rsp_valid, bus1.cmd_ready}, 2'b01);
  endtask
  initial begin
    vecs[0] = '{64'hDEADBEEF_01234567, 5'b11111, 0, 1'b0, 1'b1, 8'd5, 1'b1};
    vecs[1] = '{64'h0000_1111_2222_3333, 5'b00101, 0, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[2] = '{64'hCAFE_F00D_1357_9BDF, 5'b01011, 6, 1'b1, 1'b1, 8'd3, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0001, 5'b00000, 0, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 5'b11110, 2, 1'b0, 1'b1, 8'd4, 1'b0};
    bus0.cmd_valid = 1'b0;
    bus0.cmd_challenge = '0;
    bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0;
    bus1.cmd_challenge = '0;
    bus1.rsp_ready = 1'b1;
    #2;
    chk("reset_outputs", {pc0, bus0.rsp_valid, bus0.rsp_bit, bus0.rsp_ones}, 0);
    chk("reset_busy_ready", {busy0, bus0.cmd_ready}, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {busy0, bus0.cmd_ready}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset_mid_sample();
      run_eval(vecs[i]);
    end
    run_small(1'b0);
    run_small(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
